// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared sizing helpers and parameter legality checks for the parametrised FIFO
package sync_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction

    function automatic bit levels_ok(input int depth, input int af_level, input int ae_level);
        return af_level >= 1 && af_level <= depth && ae_level >= 0 && ae_level <= depth - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_W simple dual-port storage, synchronous write, asynchronous read
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] write_addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [$clog2(DEPTH)-1:0] read_addr,
    output logic [DATA_W-1:0]        read_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is never cleared; only accepted writes touch it
    always_ff @(posedge clk) begin
        if (write_en) mem[write_addr] <= write_data;
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO using all DEPTH slots, with occupancy, threshold flags and error pulses
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_enable,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   read_enable,
    output logic [DATA_W-1:0]      data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $fatal(1, "sync_fifo_param: AF_LEVEL/AE_LEVEL out of range");
    end

    logic [PW-1:0]     write_ptr;
    logic [PW-1:0]     read_ptr;
    logic [DATA_W-1:0] mem_data;
    logic              wr_ok;
    logic              rd_ok;

    // The wrap bit distinguishes full from empty when the address bits coincide
    assign empty        = write_ptr == read_ptr;
    assign full         = write_ptr[AW-1:0] == read_ptr[AW-1:0] && write_ptr[AW] != read_ptr[AW];
    assign almost_full  = count >= PW'(AF_LEVEL);
    assign almost_empty = count <= PW'(AE_LEVEL);
    assign wr_ok        = write_enable && !full;
    assign rd_ok        = read_enable && !empty;

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk        (clk),
        .write_en   (wr_ok),
        .write_addr (write_ptr[AW-1:0]),
        .write_data (data_in),
        .read_addr  (read_ptr[AW-1:0]),
        .read_data  (mem_data)
    );

    // Pointers, occupancy and one-cycle rejection pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            write_ptr <= write_ptr + PW'(wr_ok);
            read_ptr  <= read_ptr + PW'(rd_ok);
            count     <= count + PW'(wr_ok) - PW'(rd_ok);
            overflow  <= write_enable && full;
            underflow <= read_enable && empty;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = mem_data;
    end else begin : g_reg
        // Registered read: capture the head word on each accepted pop, hold otherwise
        always_ff @(posedge clk) begin
            if (reset) data_out <= '0;
            else if (rd_ok) data_out <= mem_data;
        end
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised successor to the team's 8x8 synchronous FIFO. Width, depth, almost-full/almost-empty thresholds and read mode are configurable. It uses every storage slot, so it holds DEPTH entries rather than DEPTH-1. It adds an occupancy count and one-cycle overflow/underflow error pulses, and sits between producer and consumer logic in a single clock domain.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
write_enable  in  1  write request
data_in  in  DATA_W  write data
read_enable  in  1  read request (pop)
data_out  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write requested while full
underflow  out  1  one-cycle pulse: read requested while empty

Behaviour:
- Reset: synchronous and active-high; it takes priority over all other activity, including a reset asserted mid-burst. On reset:
  - write_ptr = 0, read_ptr = 0, count = 0
  - data_out = 0, overflow = 0, underflow = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - Memory contents are not cleared.
- Pointers: $clog2(DEPTH)+1 bits, where the extra bit is a wrap bit.
  - empty when pointers are fully equal.
  - full when the address bits are equal and the wrap bits differ.
  - count is registered and must always equal write_ptr - read_ptr (modulo 2*DEPTH).
- Write acceptance: wr_ok = write_enable && !full, evaluated on pre-edge state. On the edge, mem[write_ptr address] <= data_in and write_ptr increments.
- Read acceptance: rd_ok = read_enable && !empty, evaluated on pre-edge state; read_ptr increments.
- Simultaneous read and write:
  - Neither full nor empty: both are accepted and count is unchanged.
  - When full: the read is accepted, the write is rejected and overflow pulses.
  - When empty: the write is accepted, the read is rejected and underflow pulses.
  - Write-through-on-full and read-through-on-empty are not supported.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- All flags are combinational from the registered count and pointers, so they are valid in the same cycle as the state change.
- overflow and underflow are registered. Each is high for exactly the cycle after the rejected request, and high on consecutive cycles if rejections repeat.
- FWFT=0 mode:
  - On rd_ok, data_out <= mem[read_ptr address]; the value is visible the cycle after the pop.
  - data_out holds its value when there is no rd_ok, including while empty.
- FWFT=1 mode:
  - data_out = mem[read_ptr address] combinationally. It is valid whenever empty = 0 and is don't-care when empty.
  - rd_ok advances to the next word. Reset forces the pointer to 0 and does not force data_out.
- Wrap-around: the address wraps from DEPTH-1 to 0 and the wrap bit toggles. No entries are lost across the wrap.
- Elaboration check: DEPTH not a power of two, or AF_LEVEL/AE_LEVEL out of range, causes a $fatal at elaboration.

Decomposition:
- Package sync_fifo_pkg holds:
  - function ptr_w(depth) returning $clog2(depth)+1
  - localparam-style range checks, shared with the bench
- One sub-module, sync_fifo_mem: DEPTH x DATA_W simple dual-port array.
  - Synchronous write port.
  - Asynchronous read port; the registered read stage lives in the parent.
- Pointer, count, flag and error logic stay in sync_fifo_param.

Test Plan:
- Reset then idle, DATA_W=8, DEPTH=8 -> empty=1, almost_empty=1, count=0, full=0, data_out=0, overflow=underflow=0.
- Write 0x01..0x08 in 8 cycles, then one more write of 0x09 -> full=1 and count=8 after the 8th write; almost_full=1 from count 7; overflow pulses 1 cycle; 0x09 is dropped.
- Read 9 times (FWFT=0) -> data_out = 0x01..0x08, each one cycle after its pop; empty=1 after the 8th pop; 9th read gives an underflow pulse and data_out holds 0x08.
- Interleave 20 writes and reads with simultaneous read+write at count=3 across a pointer wrap -> count stays 3 on simultaneous cycles; data order preserved across the wrap; no error pulses.
- Full and both enables asserted -> read accepted, write rejected, count=7, overflow=1. Empty and both asserted -> count=1, underflow=1.
- FWFT=1, write 0xA5 -> data_out=0xA5 while empty=0 with no read; assert reset mid-burst (count=5) -> next cycle count=0, empty=1, flags at reset values.
